icache: RTL and testbench

Direct-mapped, word-granular instruction cache between the instruction fetcher and the byte-serial memory controller. It serves fetcher requests from a local array on a hit. On a miss it issues one word-refill request downstream, fills the line, then returns the instruction. It discards results of fetches cancelled by a ROB flush and keeps the downstream handshake intact.

---
 rtl/icache.sv | 130 +++++++++++++
 tb/tb_icache.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/icache.sv
// Direct-mapped, one-word-per-line instruction cache with single outstanding refill.
// Optional hit/miss counters are built when ICACHE_PERF_EN is defined.
module icache #(
    parameter int INDEX_BIT = 7,
    parameter int ADDR_BIT  = 18
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        rdy_in,
    input  logic        rob_clear,
    input  logic        need_inst,
    input  logic [31:0] inst_addr,
    output logic        inst_ready,
    output logic [31:0] inst_out,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_ready,
    input  logic [31:0] mem_data
`ifdef ICACHE_PERF_EN
    ,
    output logic [31:0] hit_cnt,
    output logic [31:0] miss_cnt
`endif
);
    localparam int LINES = 1 << INDEX_BIT;
    localparam int TAG_W = ADDR_BIT - INDEX_BIT - 2;

    typedef enum logic [1:0] {IDLE, REFILL, DRAIN} state_t;

    state_t state, state_d;

    logic [LINES-1:0]     valid;
    logic [TAG_W-1:0]     tag_arr  [LINES];
    logic [31:0]          data_arr [LINES];
    logic [31:2]          req_addr;

    logic [INDEX_BIT-1:0] rd_idx, wr_idx;
    logic [TAG_W-1:0]     rd_tag, wr_tag;
    logic                 accept, hit, line_we, ready_d;
    logic [31:0]          out_d;
    logic                 addr_lsb_unused;

    assign addr_lsb_unused = ^inst_addr[1:0];

    assign rd_idx = inst_addr[INDEX_BIT+1:2];
    assign rd_tag = inst_addr[ADDR_BIT-1:INDEX_BIT+2];
    assign wr_idx = req_addr[INDEX_BIT+1:2];
    assign wr_tag = req_addr[ADDR_BIT-1:INDEX_BIT+2];

    assign hit    = valid[rd_idx] && (tag_arr[rd_idx] == rd_tag);
    // A pending pulse blocks acceptance, which caps throughput at one per 2 cycles.
    assign accept = (state == IDLE) && need_inst && !inst_ready && !rob_clear;

    // The request line follows the FSM so an async reset withdraws it at once.
    assign mem_req  = (state != IDLE);
    assign mem_addr = {req_addr, 2'b00};

    always_comb begin
        state_d = state;
        ready_d = 1'b0;
        out_d   = inst_out;
        line_we = 1'b0;
        case (state)
            IDLE: begin
                if (accept && hit) begin
                    ready_d = 1'b1;
                    out_d   = data_arr[rd_idx];
                end else if (accept) begin
                    state_d = REFILL;
                end
            end
            REFILL: begin
                if (mem_ready) begin
                    line_we = 1'b1;
                    state_d = IDLE;
                    if (!rob_clear) begin
                        ready_d = 1'b1;
                        out_d   = mem_data;
                    end
                end else if (rob_clear) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                // Flushed fetch: still capture the word, it is valid memory content.
                if (mem_ready) begin
                    line_we = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state      <= IDLE;
            valid      <= '0;
            inst_ready <= 1'b0;
            inst_out   <= '0;
            req_addr   <= '0;
        end else if (rdy_in) begin
            state      <= state_d;
            inst_ready <= ready_d;
            inst_out   <= out_d;
            if (accept) req_addr <= inst_addr[31:2];
            if (line_we) valid[wr_idx] <= 1'b1;
        end
    end

    always_ff @(posedge clk_in) begin
        if (rdy_in && line_we) begin
            tag_arr[wr_idx]  <= wr_tag;
            data_arr[wr_idx] <= mem_data;
        end
    end

`ifdef ICACHE_PERF_EN
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            hit_cnt  <= '0;
            miss_cnt <= '0;
        end else if (rdy_in && accept) begin
            if (hit && hit_cnt != '1) hit_cnt <= hit_cnt + 32'd1;
            if (!hit && miss_cnt != '1) miss_cnt <= miss_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_icache.sv
// Directed bench for icache: miss/hit/conflict, flush cases, stalls, wrap, reset mid-refill.
module tb_icache;
    logic        clk_in = 1'b0;
    logic        rst_in, rdy_in, rob_clear, need_inst, mem_ready;
    logic [31:0] inst_addr, mem_data;
    logic        inst_ready, mem_req;
    logic [31:0] inst_out, mem_addr;
`ifdef ICACHE_PERF_EN
    logic [31:0] hit_cnt, miss_cnt;
`endif

    int checks = 0;
    int fails  = 0;
    int pulses = 0;

    icache dut (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .rob_clear(rob_clear),
        .need_inst(need_inst), .inst_addr(inst_addr), .inst_ready(inst_ready),
        .inst_out(inst_out), .mem_req(mem_req), .mem_addr(mem_addr),
        .mem_ready(mem_ready), .mem_data(mem_data)
`ifdef ICACHE_PERF_EN
        , .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
`endif
    );

    always #5 clk_in = ~clk_in;

    // Consumer view: one delivered instruction per enabled edge with inst_ready high.
    always @(posedge clk_in) if (!rst_in && rdy_in && inst_ready) pulses++;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_in);
        #1;
    endtask

    task automatic req(input logic [31:0] a);
        need_inst = 1'b1;
        inst_addr = a;
        step();
        need_inst = 1'b0;
    endtask

    task automatic resp(input logic [31:0] d);
        mem_ready = 1'b1;
        mem_data  = d;
        step();
        mem_ready = 1'b0;
    endtask

    initial begin
        rst_in = 1'b1; rdy_in = 1'b1; rob_clear = 1'b0; need_inst = 1'b0;
        mem_ready = 1'b0; inst_addr = '0; mem_data = '0;
        step(); step();
        check("rst_ready", {31'd0, inst_ready}, 32'd0);
        check("rst_req", {31'd0, mem_req}, 32'd0);
        check("rst_maddr", mem_addr, 32'd0);
        check("rst_out", inst_out, 32'd0);
        rst_in = 1'b0;
        step();

        // Cold miss, memory answers four cycles after mem_req rises
        req(32'h10);
        check("cold_req", {31'd0, mem_req}, 32'd1);
        check("cold_maddr", mem_addr, 32'h10);
        check("cold_noready", {31'd0, inst_ready}, 32'd0);
        step(); step(); step();
        check("cold_req_held", {31'd0, mem_req}, 32'd1);
        resp(32'h0051_0113);
        check("cold_ready", {31'd0, inst_ready}, 32'd1);
        check("cold_out", inst_out, 32'h0051_0113);
        check("cold_req_drop", {31'd0, mem_req}, 32'd0);
        step();
        check("cold_pulse_end", {31'd0, inst_ready}, 32'd0);
        check("cold_pulses", pulses, 32'd1);

        // Hit
        req(32'h10);
        check("hit_ready", {31'd0, inst_ready}, 32'd1);
        check("hit_out", inst_out, 32'h0051_0113);
        check("hit_noreq", {31'd0, mem_req}, 32'd0);
        step();

        // Conflict on index 4
        req(32'h210);
        check("conf_req", {31'd0, mem_req}, 32'd1);
        check("conf_maddr", mem_addr, 32'h210);
        resp(32'hAAAA_0001);
        check("conf_out", inst_out, 32'hAAAA_0001);
        step();
        req(32'h10);
        check("conf_remiss", {31'd0, mem_req}, 32'd1);
        resp(32'h0051_0113);
        step();

        // Flush one cycle after mem_req rises
        req(32'h40);
        rob_clear = 1'b1;
        step();
        rob_clear = 1'b0;
        check("drain_req_held", {31'd0, mem_req}, 32'd1);
        step();
        resp(32'h1234_5678);
        check("drain_noready", {31'd0, inst_ready}, 32'd0);
        check("drain_req_drop", {31'd0, mem_req}, 32'd0);
        step();
        check("drain_pulses", pulses, 32'd4);
        req(32'h40);
        check("drain_hit", {31'd0, inst_ready}, 32'd1);
        check("drain_hit_out", inst_out, 32'h1234_5678);
        step();

        // mem_ready together with rob_clear
        req(32'h80);
        step();
        rob_clear = 1'b1;
        mem_ready = 1'b1;
        mem_data  = 32'hCAFE_F00D;
        step();
        rob_clear = 1'b0;
        mem_ready = 1'b0;
        check("sim_noready", {31'd0, inst_ready}, 32'd0);
        check("sim_idle", {31'd0, mem_req}, 32'd0);
        req(32'h80);
        check("sim_hit", {31'd0, inst_ready}, 32'd1);
        check("sim_hit_out", inst_out, 32'hCAFE_F00D);
        check("sim_hit_noreq", {31'd0, mem_req}, 32'd0);
        step();

        // Stall during refill, then during the delivery pulse
        req(32'hC0);
        rdy_in = 1'b0;
        step(); step(); step();
        check("stall_req", {31'd0, mem_req}, 32'd1);
        check("stall_maddr", mem_addr, 32'hC0);
        rdy_in = 1'b1;
        resp(32'h0BAD_BEEF);
        check("stall_ready", {31'd0, inst_ready}, 32'd1);
        rdy_in = 1'b0;
        step(); step(); step();
        check("stall_ready_held", {31'd0, inst_ready}, 32'd1);
        check("stall_out_held", inst_out, 32'h0BAD_BEEF);
        rdy_in = 1'b1;
        step();
        check("stall_ready_end", {31'd0, inst_ready}, 32'd0);
        check("stall_pulses", pulses, 32'd7);

        // Bits above ADDR_BIT alias onto the same line
        req(32'h8004_0010);
        check("wrap_hit", {31'd0, inst_ready}, 32'd1);
        check("wrap_out", inst_out, 32'h0051_0113);
        step();
        // High bits and ignored low bits on a miss
        req(32'h8000_0303);
        check("hi_maddr", mem_addr, 32'h8000_0300);
        resp(32'h0000_0013);
        check("hi_out", inst_out, 32'h0000_0013);
        step();
        check("total_pulses", pulses, 32'd9);

`ifdef ICACHE_PERF_EN
        check("hit_cnt", hit_cnt, 32'd4);
        check("miss_cnt", miss_cnt, 32'd7);
`endif

        // Async reset mid-refill withdraws the request and clears the lines
        req(32'h100);
        check("arst_req_before", {31'd0, mem_req}, 32'd1);
        rst_in = 1'b1;
        #1;
        check("arst_req_drop", {31'd0, mem_req}, 32'd0);
        step();
        rst_in = 1'b0;
        step();
        req(32'h10);
        check("arst_cold_again", {31'd0, mem_req}, 32'd1);
        resp(32'h0051_0113);
        check("arst_out", inst_out, 32'h0051_0113);
        step();

        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end
endmodule
